// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin pick helper for the packet arbiter.
//   arb_state_t : arbiter FSM state (idle/arbitrate, packet in progress)
//   rr_pick     : first set request bit above 'last', wrapping modulo n
package axis_arb_pkg;

  localparam int unsigned MAX_SRC = 16;
  localparam int unsigned PICK_W  = 4;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_t;

  // Search upward from last+1, wrapping at n. Returns 'last' when req is empty.
  function automatic logic [PICK_W-1:0] rr_pick(
    input logic [MAX_SRC-1:0] req,
    input logic [PICK_W-1:0]  last,
    input int unsigned        n
  );
    logic [PICK_W-1:0] pick;
    logic              found;
    int unsigned       idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_SRC; k++) begin
      idx = (32'(last) + k) % n;
      if (!found && (k <= n) && req[PICK_W'(idx)]) begin
        pick  = PICK_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry valid/ready register slice with full throughput.
//   clk, rst          : clock, asynchronous active-high reset
//   up_valid/up_ready : upstream handshake, up_data payload
//   dn_valid/dn_ready : downstream handshake, dn_data payload (registered)
module axis_reg_slice #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up_valid,
  output logic                  up_ready,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  dn_valid,
  input  logic                  dn_ready,
  output logic [DATA_WIDTH-1:0] dn_data
);

  // Accept whenever the register is empty or being drained this cycle.
  assign up_ready = ~dn_valid | dn_ready;

  // Load wins over drain so back-to-back beats keep the register full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_valid && up_ready) begin
      dn_valid <= 1'b1;
      dn_data  <= up_data;
    end else if (dn_ready) begin
      dn_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-stream sink among
// NUM_SRC sources. A granted source keeps the sink until its TLAST beat is
// accepted; one idle arbitration cycle separates packets.
//   ACLK, ARESET       : clock, asynchronous active-high reset
//   S_T*               : per-source streams, source i at slice i
//   M_T*               : registered shared output stream
//   SRC_EN             : enable mask, only consulted while arbitrating
//   GRANT_IDX          : current or most recently granted source
//   BUSY               : a packet is in progress
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                ACLK,
  input  logic                                ARESET,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]       S_TDATA,
  input  logic [NUM_SRC*(DATA_WIDTH/8)-1:0]   S_TKEEP,
  input  logic [NUM_SRC-1:0]                  S_TLAST,
  input  logic [NUM_SRC-1:0]                  S_TVALID,
  output logic [NUM_SRC-1:0]                  S_TREADY,
  output logic [DATA_WIDTH-1:0]               M_TDATA,
  output logic [DATA_WIDTH/8-1:0]             M_TKEEP,
  output logic                                M_TLAST,
  output logic                                M_TVALID,
  input  logic                                M_TREADY,
  input  logic [NUM_SRC-1:0]                  SRC_EN,
  output logic [$clog2(NUM_SRC)-1:0]          GRANT_IDX,
  output logic                                BUSY
);

  localparam int unsigned KEEP_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = $clog2(NUM_SRC);
  localparam int unsigned PAY_W  = DATA_WIDTH + KEEP_W + 1;

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [MAX_SRC-1:0]  req_ext;
  logic [PICK_W-1:0]   pick;

  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_W-1:0]     sel_keep;
  logic                  sel_last;
  logic                  sel_valid;
  logic                  slice_valid;
  logic                  slice_ready;
  logic [PAY_W-1:0]      slice_out;

  // Requests seen by the arbiter, widened for the shared pick helper.
  always_comb begin
    req_ext = MAX_SRC'(S_TVALID & SRC_EN);
    pick    = rr_pick(req_ext, PICK_W'(last_q), NUM_SRC);
  end

  // Grant mux: route the granted source towards the output slice.
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_data  = S_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = S_TKEEP[i*KEEP_W +: KEEP_W];
        sel_last  = S_TLAST[i];
        sel_valid = S_TVALID[i];
      end
    end
  end

  // Next-state, grant bookkeeping and source ready.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    S_TREADY    = '0;
    slice_valid = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (req_ext != '0) begin
          grant_d = IDX_W'(pick);
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          if (grant_q == IDX_W'(i)) S_TREADY[i] = slice_ready;
        end
        slice_valid = sel_valid;
        // Packet ends on the accepted TLAST beat; it becomes the new RR origin.
        if (sel_valid && slice_ready && sel_last) begin
          state_d = ARB_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers; pointer resets to the top source so source 0 wins first.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_SRC - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  axis_reg_slice #(
    .DATA_WIDTH (PAY_W)
  ) u_out_slice (
    .clk      (ACLK),
    .rst      (ARESET),
    .up_valid (slice_valid),
    .up_ready (slice_ready),
    .up_data  ({sel_last, sel_keep, sel_data}),
    .dn_valid (M_TVALID),
    .dn_ready (M_TREADY),
    .dn_data  (slice_out)
  );

  assign {M_TLAST, M_TKEEP, M_TDATA} = slice_out;
  assign GRANT_IDX = grant_q;
  assign BUSY      = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter (NUM_SRC=4, DATA_WIDTH=32).
module tb_axis_packet_arbiter;

  localparam int unsigned NS    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned KW    = DW / 8;
  localparam int unsigned DEPTH = 128;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    logic [NS-1:0] en;
    logic [NS-1:0] valid;
    int unsigned   grant;
  } arb_vec_t;

  logic              clk;
  logic              rst;
  logic [NS*DW-1:0]  s_tdata;
  logic [NS*KW-1:0]  s_tkeep;
  logic [NS-1:0]     s_tlast;
  logic [NS-1:0]     s_tvalid;
  logic [NS-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic [NS-1:0]     src_en;
  logic [1:0]        grant_idx;
  logic              busy;

  axis_packet_arbiter #(
    .NUM_SRC    (NS),
    .DATA_WIDTH (DW)
  ) dut (
    .ACLK      (clk),
    .ARESET    (rst),
    .S_TDATA   (s_tdata),
    .S_TKEEP   (s_tkeep),
    .S_TLAST   (s_tlast),
    .S_TVALID  (s_tvalid),
    .S_TREADY  (s_tready),
    .M_TDATA   (m_tdata),
    .M_TKEEP   (m_tkeep),
    .M_TLAST   (m_tlast),
    .M_TVALID  (m_tvalid),
    .M_TREADY  (m_tready),
    .SRC_EN    (src_en),
    .GRANT_IDX (grant_idx),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests;
  int unsigned fails;

  // Source-side packet storage and reference model state.
  beat_t        mem [NS][DEPTH];
  int unsigned  hd [NS];
  int unsigned  tl [NS];
  logic [NS-1:0] cur_valid;
  beat_t        exp_q [$];
  bit           model_busy;
  int unsigned  model_g;
  int unsigned  model_last;
  bit           m_full;
  int unsigned  cyc;
  int unsigned  dut_g0;
  bit           log_en;
  logic [DW-1:0] out_log [$];
  int unsigned  grant_log [$];
  arb_vec_t     tbl [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Round-robin rule: rotate the request vector so last+1 sits at bit 0.
  function automatic int unsigned rr_ref(input logic [NS-1:0] req, input int unsigned last);
    logic [2*NS-1:0] rot;
    rot = {req, req} >> (last + 1);
    for (int unsigned k = 0; k < NS; k++) if (rot[k]) return (last + 1 + k) % NS;
    return last;
  endfunction

  task automatic clear_srcs();
    for (int unsigned i = 0; i < NS; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    cur_valid = '0;
  endtask

  task automatic add_pkt(input int unsigned src, input int unsigned len,
                         input logic [DW-1:0] base, input bit rnd_data);
    beat_t b;
    for (int unsigned k = 0; k < len; k++) begin
      b.data = rnd_data ? DW'($urandom) : base + DW'(k);
      b.keep = rnd_data ? (KW'($urandom) | KW'(1)) : {KW{1'b1}};
      b.last = (k == len - 1);
      mem[src][tl[src]] = b;
      tl[src]++;
    end
  endtask

  task automatic drive_srcs(input bit rnd);
    beat_t b;
    for (int unsigned i = 0; i < NS; i++) begin
      if (hd[i] == tl[i]) cur_valid[i] = 1'b0;
      else if (!cur_valid[i]) cur_valid[i] = rnd ? ($urandom_range(2, 0) != 0) : 1'b1;
      if (hd[i] < tl[i]) b = mem[i][hd[i]];
      else b = '0;
      s_tdata[i*DW +: DW] = b.data;
      s_tkeep[i*KW +: KW] = b.keep;
      s_tlast[i]          = b.last;
    end
    s_tvalid = cur_valid;
  endtask

  // One cycle of randomized traffic checked against the packet-level model.
  task automatic eng_step(input bit rnd_valid, input int unsigned rdy_mode, input bit rnd_en,
                          input logic [NS-1:0] base_en);
    logic [NS-1:0] sv, sr, en_s, req, hs, exp_rdy;
    logic          mv, mr, busy_pre_dut;
    logic [3:0]    pat;
    beat_t         mpre, e;
    bit            busy_pre;
    pat = 4'b1001;
    drive_srcs(rnd_valid);
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = pat[2'(cyc % 4)];
      default: m_tready = ($urandom_range(3, 0) != 0);
    endcase
    src_en = rnd_en ? NS'($urandom) : base_en;
    #1;
    sv = s_tvalid; sr = s_tready; en_s = src_en;
    mv = m_tvalid; mr = m_tready;
    mpre = '{data: m_tdata, keep: m_tkeep, last: m_tlast};
    busy_pre = model_busy;
    busy_pre_dut = busy;
    exp_rdy = (model_busy && (!mv || mr)) ? (NS'(1) << model_g) : '0;
    check("s_tready", 64'(sr), 64'(exp_rdy));
    check("m_tvalid", 64'(mv), 64'(m_full));
    @(posedge clk);
    #1;
    cyc++;
    hs = sv & sr;
    if (mv && mr) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL m_beat_extra: actual=%0h required=none", mpre);
      end else begin
        e = exp_q.pop_front();
        check("m_beat", 64'(mpre), 64'(e));
        if (log_en) out_log.push_back(mpre.data);
      end
    end
    if (mv && !mr)
      check("m_hold", 64'({m_tvalid, m_tdata, m_tkeep, m_tlast}), 64'({1'b1, mpre}));
    for (int unsigned i = 0; i < NS; i++) begin
      if (hs[i]) begin
        if (mem[i][hd[i]].last) begin
          model_busy = 1'b0;
          model_last = model_g;
        end
        hd[i]++;
        cur_valid[i] = 1'b0;
      end
    end
    m_full = (hs != '0) || (m_full && !mr);
    req = sv & en_s;
    if (!busy_pre && req != '0) begin
      model_g = rr_ref(req, model_last);
      model_busy = 1'b1;
      for (int unsigned j = hd[model_g]; j < tl[model_g]; j++) begin
        exp_q.push_back(mem[model_g][j]);
        if (mem[model_g][j].last) break;
      end
      check("grant_idx", 64'(grant_idx), 64'(model_g));
    end
    if (!busy_pre_dut && busy) begin
      if (grant_idx == 2'd0) dut_g0++;
      if (log_en) grant_log.push_back(32'(grant_idx));
    end
    check("busy", 64'(busy), 64'(model_busy));
  endtask

  task automatic run_engine(input bit rnd_valid, input int unsigned rdy_mode, input bit rnd_en,
                            input logic [NS-1:0] base_en, input logic [NS-1:0] done_mask,
                            input int unsigned budget);
    bit done;
    int unsigned n;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      eng_step(rnd_valid, rdy_mode, rnd_en, base_en);
      n++;
      done = (exp_q.size() == 0) && !model_busy && !m_full;
      for (int unsigned i = 0; i < NS; i++)
        if (done_mask[i] && hd[i] != tl[i]) done = 1'b0;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL engine_timeout: actual=%0d cycles required=drained", n);
    end
    s_tvalid = '0;
    m_tready = 1'b1;
  endtask

  task automatic set_src(input int unsigned i, input logic [DW-1:0] d, input logic last);
    s_tdata[i*DW +: DW] = d;
    s_tkeep[i*KW +: KW] = {KW{1'b1}};
    s_tlast[i]          = last;
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 4'b0001, 0};
    tbl[1]  = '{4'b1111, 4'b1111, 1};
    tbl[2]  = '{4'b1111, 4'b1111, 2};
    tbl[3]  = '{4'b1111, 4'b1111, 3};
    tbl[4]  = '{4'b1111, 4'b1010, 1};
    tbl[5]  = '{4'b1111, 4'b1000, 3};
    tbl[6]  = '{4'b1111, 4'b0001, 0};
    tbl[7]  = '{4'b1110, 4'b1111, 1};
    tbl[8]  = '{4'b1110, 4'b1111, 2};
    tbl[9]  = '{4'b1110, 4'b1111, 3};
    tbl[10] = '{4'b1110, 4'b1111, 1};
    tbl[11] = '{4'b1111, 4'b0101, 2};

    tests = 0; fails = 0; cyc = 0; dut_g0 = 0; log_en = 1'b0;
    rst = 1'b1;
    s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tvalid = '0;
    m_tready = 1'b0; src_en = '0;
    clear_srcs();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_m_payload", 64'({m_tdata, m_tkeep, m_tlast}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_grant", 64'(grant_idx), 64'(0));
    check("rst_s_tready", 64'(s_tready), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Source 0 three-beat packet, 2-cycle first-beat latency
    src_en = 4'b1111; m_tready = 1'b1;
    set_src(0, 32'hA0, 1'b0); s_tvalid = 4'b0001;
    @(posedge clk); #1;
    check("a_busy", 64'(busy), 64'(1));
    check("a_grant", 64'(grant_idx), 64'(0));
    check("a_no_early_beat", 64'(m_tvalid), 64'(0));
    @(posedge clk); #1;
    check("a_beat0", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, 1'b0, 32'hA0}));
    set_src(0, 32'hA1, 1'b0);
    @(posedge clk); #1;
    check("a_beat1", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, 1'b0, 32'hA1}));
    set_src(0, 32'hA2, 1'b1);
    @(posedge clk); #1;
    check("a_beat2", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, 1'b1, 32'hA2}));
    check("a_busy_drop", 64'(busy), 64'(0));
    s_tvalid = '0;
    @(posedge clk); #1;
    check("a_drain", 64'(m_tvalid), 64'(0));

    // Table: single-beat packets exercising the round-robin pointer and SRC_EN
    for (int unsigned t = 0; t < 12; t++) begin
      src_en = tbl[t].en;
      m_tready = 1'b1;
      for (int unsigned i = 0; i < NS; i++) set_src(i, 32'hC000_0000 | (t << 8) | i, 1'b1);
      s_tvalid = tbl[t].valid;
      @(posedge clk); #1;
      check("tbl_busy", 64'(busy), 64'(1));
      check("tbl_grant", 64'(grant_idx), 64'(tbl[t].grant));
      check("tbl_ready", 64'(s_tready), 64'(NS'(1) << tbl[t].grant));
      @(posedge clk); #1;
      s_tvalid = '0;
      check("tbl_data", 64'(m_tdata), 64'(32'hC000_0000 | (t << 8) | tbl[t].grant));
      check("tbl_idle", 64'(busy), 64'(0));
      @(posedge clk); #1;
      check("tbl_drain", 64'(m_tvalid), 64'(0));
    end

    // Model engine phases; the table leaves the pointer at source 2.
    model_busy = 1'b0; model_last = 2; m_full = 1'b0;

    // Two sources alternating 2-beat packets
    clear_srcs();
    for (int unsigned p = 0; p < 3; p++) begin
      add_pkt(0, 2, 32'h10, 1'b0);
      add_pkt(1, 2, 32'h20, 1'b0);
    end
    log_en = 1'b1;
    run_engine(1'b0, 0, 1'b0, 4'b1111, 4'b1111, 200);
    log_en = 1'b0;
    check("alt_count", 64'(out_log.size()), 64'(12));
    for (int unsigned k = 0; k < out_log.size() && k < 12; k++)
      check("alt_order", 64'(out_log[k]), 64'(((k % 4) < 2 ? 32'h10 : 32'h20) + (k % 2)));
    check("alt_grants", 64'(grant_log.size()), 64'(6));
    for (int unsigned k = 0; k < grant_log.size() && k < 6; k++)
      check("alt_grant_seq", 64'(grant_log[k]), 64'(k % 2));

    // Backpressure 1,0,0,1 on a 4-beat packet
    clear_srcs();
    add_pkt(2, 4, 32'hB0, 1'b0);
    run_engine(1'b0, 1, 1'b0, 4'b1111, 4'b1111, 100);

    // Source 0 masked while everyone requests
    clear_srcs();
    for (int unsigned i = 0; i < NS; i++)
      for (int unsigned p = 0; p < 3; p++) add_pkt(i, $urandom_range(4, 1), '0, 1'b1);
    dut_g0 = 0;
    run_engine(1'b1, 2, 1'b0, 4'b1110, 4'b1110, 2000);
    check("src0_never_granted", 64'(dut_g0), 64'(0));

    // Random SRC_EN every cycle (includes disabling the owner mid-packet)
    clear_srcs();
    for (int unsigned i = 0; i < NS; i++)
      for (int unsigned p = 0; p < 5; p++) add_pkt(i, $urandom_range(4, 1), '0, 1'b1);
    run_engine(1'b1, 2, 1'b1, 4'b0000, 4'b1111, 4000);

    // Reset pulse during beat 2 of a 4-beat packet from source 1
    src_en = 4'b1111; m_tready = 1'b1;
    @(posedge clk); #1;
    set_src(1, 32'hD0, 1'b0); s_tvalid = 4'b0010;
    @(posedge clk); #1;
    check("r_grant", 64'(grant_idx), 64'(1));
    @(posedge clk); #1;
    set_src(1, 32'hD1, 1'b0);
    @(posedge clk); #1;
    check("r_beat1", 64'({m_tvalid, m_tdata}), 64'({1'b1, 32'hD1}));
    set_src(1, 32'hD2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("r_async_m_tvalid", 64'(m_tvalid), 64'(0));
    check("r_async_s_tready", 64'(s_tready), 64'(0));
    check("r_async_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    set_src(0, 32'hE0, 1'b1);
    s_tvalid = 4'b0011;
    @(posedge clk); #1;
    check("r_regrant_busy", 64'(busy), 64'(1));
    check("r_regrant_src0", 64'(grant_idx), 64'(0));
    @(posedge clk); #1;
    check("r_first_after", 64'({m_tvalid, m_tdata}), 64'({1'b1, 32'hE0}));
    s_tvalid = '0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
